// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid buffer and split ctrl/data flush values.
// Define PIPE_STAGE_PERF_EN to build the saturating bubble counter; otherwise bubble_cnt is tied to 0.
module pipe_stage_skid #(
    parameter int                CTRL_W     = 8,
    parameter int                DATA_W     = 128,
    parameter logic [CTRL_W-1:0] CTRL_FLUSH = '0,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state, state_nx;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              acc, pop, load_main, load_skid, skid_to_main;

    // Both handshake outputs decode straight from the state flop, so neither sees a comb input path.
    assign in_ready  = state != TWO;
    assign out_valid = state != EMPTY;
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_ctrl  = out_valid ? main_ctrl : CTRL_FLUSH;
    assign out_data  = main_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= EMPTY;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    load_main = acc;
                    state_nx  = acc ? ONE : EMPTY;
                end
                ONE: begin
                    load_main = acc && pop;
                    load_skid = acc && !pop;
                    state_nx  = (acc && !pop) ? TWO : (!acc && pop) ? EMPTY : ONE;
                end
                TWO: begin
                    skid_to_main = pop;
                    state_nx     = pop ? ONE : TWO;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_ctrl <= CTRL_FLUSH;
            main_data <= '0;
            skid_ctrl <= CTRL_FLUSH;
            skid_data <= '0;
        end else if (flush) begin
            main_ctrl <= CTRL_FLUSH;
            main_data <= '0;
            skid_ctrl <= CTRL_FLUSH;
            skid_data <= '0;
        end else begin
            if (load_main) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else if (skid_to_main) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                              cnt <= '0;
        else if (out_ready && !out_valid && !flush && cnt != '1) cnt <= cnt + 1'b1;
    end

    assign bubble_cnt = cnt;
`else
    assign bubble_cnt = '0;
`endif
endmodule
